// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: parameterised hierarchical carry look-ahead adder
// with a registered sum/carry-out (fixed one-cycle latency, one result per
// cycle). Bits are grouped by four; look-ahead units of four are stacked
// in as many levels as the (padded) width needs.

// One 4-wide look-ahead unit: fully expanded carries plus group G/P.
module cla_lookahead_unit (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] c,
    output logic       gg,
    output logic       pg
);
    // c[k] is the carry into position k of this group
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;
endmodule

module carry_look_ahead_adder #(
    parameter int CLA_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [CLA_WIDTH-1:0] a_i,
    input  logic [CLA_WIDTH-1:0] b_i,
    input  logic                 carry_i,
    output logic [CLA_WIDTH-1:0] sum_o,
    output logic                 carry_o
);
    // Tree depth: each level folds four nodes into one. The operand is
    // zero-padded up to 4^LEVELS bits; padded bits have g=p=0 so they
    // never disturb the real carries.
    localparam int LEVELS = (CLA_WIDTH <= 4)  ? 1 :
                            (CLA_WIDTH <= 16) ? 2 : 3;
    localparam int PW     = 1 << (2 * LEVELS);

    if ((CLA_WIDTH < 4) || (CLA_WIDTH > 64) || ((CLA_WIDTH % 4) != 0)) begin : g_bad_width
        $error("carry_look_ahead_adder: CLA_WIDTH=%0d must be a multiple of 4 in 4..64", CLA_WIDTH);
    end

    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [CLA_WIDTH-1:0] sum_d;
    logic                 carry_d;
    logic                 unused_bits;

    assign a_ext = PW'(a_i);
    assign b_ext = PW'(b_i);

    // Level l holds PW/4^l nodes. g/p flow upward (level 0 = bits),
    // carries flow downward (root carry = carry_i).
    genvar l, u;
    for (l = 0; l <= LEVELS; l++) begin : lvl
        localparam int N = PW >> (2 * l);
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] c;

        if (l == 0) begin : g_leaf
            assign g = a_ext & b_ext;
            assign p = a_ext ^ b_ext;
        end else begin : g_node
            assign g = lvl[l-1].g_units.gg;
            assign p = lvl[l-1].g_units.pg;
        end

        if (l == LEVELS) begin : g_root
            assign c = carry_i;
        end else begin : g_units
            logic [N/4-1:0] gg;
            logic [N/4-1:0] pg;
            for (u = 0; u < N / 4; u++) begin : unit
                cla_lookahead_unit u_la (
                    .g   (g[4*u +: 4]),
                    .p   (p[4*u +: 4]),
                    .cin (lvl[l+1].c[u]),
                    .c   (c[4*u +: 4]),
                    .gg  (gg[u]),
                    .pg  (pg[u])
                );
            end
        end
    end

    assign sum_d = lvl[0].p[CLA_WIDTH-1:0] ^ lvl[0].c[CLA_WIDTH-1:0];

    // Unpadded width: carry-out is the root group's carry. Padded width:
    // the carry into the first pad bit is the carry out of the MSB.
    if (CLA_WIDTH == PW) begin : g_cout_root
        assign carry_d = lvl[LEVELS].g[0] | (lvl[LEVELS].p[0] & carry_i);
    end else begin : g_cout_pad
        assign carry_d = lvl[0].c[CLA_WIDTH];
    end

    // Pad-region carries and root G/P are only needed for some widths.
    assign unused_bits = ^{lvl[0].c, lvl[LEVELS].g, lvl[LEVELS].p};

    // Output register: async clear, otherwise capture every rising edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_o   <= '0;
            carry_o <= 1'b0;
        end else begin
            sum_o   <= sum_d;
            carry_o <= carry_d;
        end
    end
endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Bench for carry_look_ahead_adder at widths 16, 4 and 32. Expected
// {carry, sum} values are computed from the driven operands with 64-bit
// arithmetic, queued at drive time and popped one edge later.
module tb_carry_look_ahead_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        c16 = 1'b0, co16;
    logic [3:0]  a4 = '0, b4 = '0, s4;
    logic        c4 = 1'b0, co4;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        c32 = 1'b0, co32;

    logic [63:0] q16[$];
    logic [63:0] q4[$];
    logic [63:0] q32[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carry_look_ahead_adder #(.CLA_WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a16), .b_i(b16), .carry_i(c16),
        .sum_o(s16), .carry_o(co16));
    carry_look_ahead_adder #(.CLA_WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a4), .b_i(b4), .carry_i(c4),
        .sum_o(s4), .carry_o(co4));
    carry_look_ahead_adder #(.CLA_WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a32), .b_i(b32), .carry_i(c32),
        .sum_o(s32), .carry_o(co32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
        a16 = a; b16 = b; c16 = c;
        q16.push_back(64'(a) + 64'(b) + 64'(c));
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; c4 = c;
        q4.push_back(64'(a) + 64'(b) + 64'(c));
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic c);
        a32 = a; b32 = b; c32 = c;
        q32.push_back(64'(a) + 64'(b) + 64'(c));
    endtask

    // Advance one edge, compare every pending result, return at negedge.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (q16.size() > 0) chk({tag, "_w16"}, 64'({co16, s16}), q16.pop_front());
        if (q4.size()  > 0) chk({tag, "_w4"},  64'({co4, s4}),   q4.pop_front());
        if (q32.size() > 0) chk({tag, "_w32"}, 64'({co32, s32}), q32.pop_front());
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w16"}, 64'({co16, s16}), 64'd0);
        chk({tag, "_w4"},  64'({co4, s4}),   64'd0);
        chk({tag, "_w32"}, 64'({co32, s32}), 64'd0);
    endtask

    logic [15:0] da[5] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'h0FFF, 16'h8000};
    logic [15:0] db[5] = '{16'h0000, 16'hFFFF, 16'h4321, 16'h0001, 16'h8000};
    logic        dc[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        // Reset held from time zero
        @(posedge clk);
        #1;
        chk_all_zero("reset_init");

        // First edge after release captures the inputs present then
        a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive16(16'hFFFF, 16'h0001, 1'b1);
        step("rel1");

        // Mid-stream reset between edges: immediate clear, result discarded
        drive16(16'hFFFF, 16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        q16.delete(); q4.delete(); q32.delete();
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive16(16'hFFFF, 16'h0001, 1'b1);
        step("rst_first");

        // Directed corner cases, back to back; narrow/wide copies alongside
        for (int i = 0; i < 5; i++) begin
            drive16(da[i], db[i], dc[i]);
            drive4(da[i][3:0], db[i][3:0], dc[i]);
            drive32({da[i], da[i]}, {db[i], db[i]}, dc[i]);
            step($sformatf("dir%0d", i));
        end

        // Random stream, new operands every cycle on all widths
        for (int i = 0; i < 50; i++) begin
            drive16(16'($urandom), 16'($urandom), 1'($urandom));
            drive4(4'($urandom), 4'($urandom), 1'($urandom));
            drive32($urandom, $urandom, 1'($urandom));
            step($sformatf("rnd%0d", i));
        end

        chk("q_drained", 64'(q16.size() + q4.size() + q32.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
